// File: rtl/note_tone_gen.sv
// note_tone_gen: chromatic square-wave tone generator, A3..A5 in 25 semitones.
// Optional articulation gap between consecutive tones: define NOTE_GAP_EN.
module note_tone_gen #(
   parameter int unsigned GAP_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] note,
   output logic       speaker,
   output logic       tone_on
);

   localparam logic [4:0] REST_IDX = 5'd25;

   // The gap counter is 20 bits wide, so the gap length must fit in it.
   if (GAP_CYCLES > 32'd1048575) begin : g_gap_range
      $error("note_tone_gen: GAP_CYCLES exceeds 2^20-1");
   end

`ifdef NOTE_GAP_EN
   localparam logic [19:0] GAP_LAST = 20'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_REST,
      S_TONE,
      S_GAP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_REST,
      S_TONE
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [4:0]  note_q;
   logic [4:0]  cur_note_q, cur_note_d;
   logic [16:0] cnt_q, cnt_d;
   logic        speaker_q, speaker_d;
   logic        tone_on_q, tone_on_d;
`ifdef NOTE_GAP_EN
   logic [19:0] gap_q, gap_d;
`endif

   logic [16:0] hp_m1;
   logic        note_chg;
   logic        note_rest;
   logic        cnt_wrap;

   // Half period in clk cycles: round(50e6 / (2 * 220 * 2^(n/12))).
   function automatic logic [16:0] hp_rom(input logic [4:0] n);
      logic [16:0] hp;
      case (n)
         5'd0:    hp = 17'd113636;
         5'd1:    hp = 17'd107258;
         5'd2:    hp = 17'd101238;
         5'd3:    hp = 17'd95556;
         5'd4:    hp = 17'd90193;
         5'd5:    hp = 17'd85131;
         5'd6:    hp = 17'd80353;
         5'd7:    hp = 17'd75843;
         5'd8:    hp = 17'd71586;
         5'd9:    hp = 17'd67569;
         5'd10:   hp = 17'd63776;
         5'd11:   hp = 17'd60197;
         5'd12:   hp = 17'd56818;
         5'd13:   hp = 17'd53629;
         5'd14:   hp = 17'd50619;
         5'd15:   hp = 17'd47778;
         5'd16:   hp = 17'd45097;
         5'd17:   hp = 17'd42566;
         5'd18:   hp = 17'd40177;
         5'd19:   hp = 17'd37922;
         5'd20:   hp = 17'd35793;
         5'd21:   hp = 17'd33784;
         5'd22:   hp = 17'd31888;
         5'd23:   hp = 17'd30098;
         5'd24:   hp = 17'd28409;
         default: hp = 17'd113636;
      endcase
      return hp;
   endfunction

   // Decode helpers shared by every state.
   always_comb begin
      hp_m1     = hp_rom(cur_note_q) - 17'd1;
      note_chg  = (note_q != cur_note_q);
      note_rest = (note_q >= REST_IDX);
      cnt_wrap  = (cnt_q >= hp_m1);
   end

   // Next state, phase counter and speaker level.
   always_comb begin
      state_d    = state_q;
      cur_note_d = cur_note_q;
      cnt_d      = cnt_q;
      speaker_d  = speaker_q;
`ifdef NOTE_GAP_EN
      gap_d      = gap_q;
`endif
      unique case (state_q)
         S_REST: begin
            cnt_d     = '0;
            speaker_d = 1'b0;
            if (note_chg) begin
               cur_note_d = note_q;
               if (!note_rest) begin
                  state_d = S_TONE;
               end
            end
         end
         S_TONE: begin
            if (note_chg) begin
               cur_note_d = note_q;
               cnt_d      = '0;
               speaker_d  = 1'b0;
               if (note_rest) begin
                  state_d = S_REST;
               end else begin
`ifdef NOTE_GAP_EN
                  state_d = S_GAP;
                  gap_d   = '0;
`else
                  state_d = S_TONE;
`endif
               end
            end else if (cnt_wrap) begin
               cnt_d     = '0;
               speaker_d = ~speaker_q;
            end else begin
               cnt_d = cnt_q + 17'd1;
            end
         end
`ifdef NOTE_GAP_EN
         S_GAP: begin
            cnt_d     = '0;
            speaker_d = 1'b0;
            if (note_chg) begin
               cur_note_d = note_q;
               gap_d      = '0;
               if (note_rest) begin
                  state_d = S_REST;
               end
            end else if (gap_q >= GAP_LAST) begin
               gap_d   = '0;
               state_d = S_TONE;
            end else begin
               gap_d = gap_q + 20'd1;
            end
         end
`endif
         default: begin
            state_d   = S_REST;
            cnt_d     = '0;
            speaker_d = 1'b0;
         end
      endcase
      tone_on_d = (state_d == S_TONE);
   end

   // Input register: all decisions are taken on the registered note.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_q <= REST_IDX;
      end else begin
         note_q <= note;
      end
   end

   // FSM and tone state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REST;
         cur_note_q <= REST_IDX;
         cnt_q      <= '0;
         speaker_q  <= 1'b0;
         tone_on_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_note_q <= cur_note_d;
         cnt_q      <= cnt_d;
         speaker_q  <= speaker_d;
         tone_on_q  <= tone_on_d;
      end
   end

`ifdef NOTE_GAP_EN
   // Articulation gap counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`endif

   assign speaker = speaker_q;
   assign tone_on = tone_on_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed checks of note_tone_gen latency, pitch and rests.
// Expectations adapt when NOTE_GAP_EN is defined (gap of 1000 cycles).
module tb_note_tone_gen;

   logic       clk;
   logic       rst_n;
   logic [4:0] note;
   logic       speaker;
   logic       tone_on;

   int n_cmp = 0;
   int n_bad = 0;
   int n;
   int act;

   note_tone_gen #(
      .GAP_CYCLES(1000)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .note   (note),
      .speaker(speaker),
      .tone_on(tone_on)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_spk(input logic lvl, input int lim, output int cnt);
      cnt = 0;
      while (speaker !== lvl && cnt < lim) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_ton(input logic lvl, input int lim, output int cnt);
      cnt = 0;
      while (tone_on !== lvl && cnt < lim) begin
         tick();
         cnt++;
      end
   endtask

   task automatic quiet(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         tick();
         if (speaker !== 1'b0 || tone_on !== 1'b0) cnt++;
      end
   endtask

   task automatic steady(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         tick();
         if (speaker !== 1'b0 || tone_on !== 1'b1) cnt++;
      end
   endtask

   task automatic seg(input logic [4:0] nt, input int prev, input int exp);
      int a;
      note = nt;
      tick();
      chk("stream_lat1", int'(tone_on), prev);
      tick();
      chk("stream_lat2", int'(tone_on), exp);
      a = 0;
      repeat (998) begin
         tick();
         if (speaker !== 1'b0) a++;
      end
      chk("stream_no_toggle", a, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      note  = 5'd25;
      #1;
      chk("rst_speaker", int'(speaker), 0);
      chk("rst_tone_on", int'(tone_on), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("idle_tone_on", int'(tone_on), 0);

      // REST -> TONE on note 0, then 0 -> 24 in the first half period
      note = 5'd0;
      tick();
      chk("t0_lat1", int'(tone_on), 0);
      tick();
      chk("t0_lat2", int'(tone_on), 1);
      chk("t0_spk", int'(speaker), 0);
      repeat (500) tick();
      chk("t0_no_toggle", int'(speaker), 0);
      note = 5'd24;
      tick();
      chk("chg_lat1", int'(tone_on), 1);
      tick();
      chk("chg_spk", int'(speaker), 0);
`ifdef NOTE_GAP_EN
      chk("gap_tone_off", int'(tone_on), 0);
      wait_ton(1'b1, 1200, n);
      chk("gap_len", n, 1000);
      chk("gap_exit_spk", int'(speaker), 0);
`else
      chk("chg_tone_on", int'(tone_on), 1);
`endif
      wait_spk(1'b1, 30000, n);
      chk("hp24_a", n, 28409);

      // TONE -> REST in the high phase, then a rest-to-rest change
      repeat (100) tick();
      chk("hi_hold", int'(speaker), 1);
      note = 5'd25;
      tick();
      chk("rest_lat1_spk", int'(speaker), 1);
      chk("rest_lat1_ton", int'(tone_on), 1);
      tick();
      chk("rest_lat2_spk", int'(speaker), 0);
      chk("rest_lat2_ton", int'(tone_on), 0);
      note = 5'd30;
      quiet(200, act);
      chk("rest_rest_quiet", act, 0);

      // REST -> TONE (never a gap), then TONE -> TONE in the high phase
      note = 5'd24;
      tick();
      tick();
      chk("t24_lat2", int'(tone_on), 1);
      wait_spk(1'b1, 30000, n);
      chk("hp24_b", n, 28409);
      repeat (50) tick();
      note = 5'd23;
      tick();
      chk("tt_lat1_spk", int'(speaker), 1);
      tick();
      chk("tt_lat2_spk", int'(speaker), 0);
`ifdef NOTE_GAP_EN
      chk("tt_gap_ton", int'(tone_on), 0);
      wait_ton(1'b1, 1200, n);
      chk("tt_gap_len", n, 1000);
`else
      chk("tt_tone_on", int'(tone_on), 1);
`endif
      steady(300, act);
      chk("tt_phase0", act, 0);

      // Asynchronous reset mid-tone, then note 7 after release
      #5;
      rst_n = 1'b0;
      note  = 5'd7;
      #1;
      chk("arst_spk", int'(speaker), 0);
      chk("arst_ton", int'(tone_on), 0);
      #3;
      rst_n = 1'b1;
      tick();
      chk("n7_lat1", int'(tone_on), 0);
      tick();
      chk("n7_lat2", int'(tone_on), 1);
      steady(300, act);
      chk("n7_steady", act, 0);
      note = 5'd25;
      tick();
      tick();
      chk("n7_rest", int'(tone_on), 0);

      // Alternating tone/rest stream
      seg(5'd12, 0, 1);
      seg(5'd25, 1, 0);
      seg(5'd7, 0, 1);
      seg(5'd25, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
